// File: rtl/servo_pwm_avalon.sv
// Avalon-MM servo PWM generator with response-pulse width measurement and timeout.
// Define SERVO_PWM_CLAMP_EN to clamp PULSE writes to [MIN_PULSE, MAX_PULSE] instead of [0, PERIOD_CYCLES].
module servo_pwm_avalon #(
  parameter int PERIOD_CYCLES = 1000000,
  parameter int MIN_PULSE     = 50000,
  parameter int MAX_PULSE     = 100000,
  parameter int MEAS_W        = 21
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  avs_address,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  input  logic        avs_read,
  output logic [31:0] avs_readdata,
  output logic        pwm_out,
  input  logic        pwm_response
);

  localparam logic [31:0] PERIOD = 32'(PERIOD_CYCLES);
  localparam logic [31:0] LAST   = 32'(PERIOD_CYCLES - 1);
  localparam logic [31:0] TO_LIM = 32'(2 * PERIOD_CYCLES);
  localparam logic [31:0] MINP   = 32'(MIN_PULSE);
  localparam logic [31:0] MAXP   = 32'(MAX_PULSE);
  localparam logic [MEAS_W-1:0] MEAS_MAX = {MEAS_W{1'b1}};
`ifdef SERVO_PWM_CLAMP_EN
  localparam bit CLAMP_EN = 1'b1;
`else
  localparam bit CLAMP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_HIGH, S_DONE} meas_state_t;

  logic              en;
  logic [31:0]       pulse, pulse_act, pulse_now, frame_cnt, to_cnt;
  logic              resp_s1, resp_s2, resp_d, rise, fall;
  meas_state_t       state;
  logic [MEAS_W-1:0] meas_cnt, meas;
  logic              meas_valid, timeout, to_set;
  logic              wr_ctrl, wr_pulse, rd_status;
  logic [31:0]       rd_mux;

  function automatic logic [31:0] clamp_pulse(input logic [31:0] v);
    logic [31:0] lo, hi;
    lo = CLAMP_EN ? MINP : '0;
    hi = CLAMP_EN ? MAXP : PERIOD;
    if (v < lo)      clamp_pulse = lo;
    else if (v > hi) clamp_pulse = hi;
    else             clamp_pulse = v;
  endfunction

  assign wr_ctrl   = avs_write && (avs_address == 2'd0);
  assign wr_pulse  = avs_write && (avs_address == 2'd1);
  assign rd_status = avs_read  && (avs_address == 2'd3);
  assign rise      = resp_s2 && !resp_d;
  assign fall      = !resp_s2 && resp_d;
  assign to_set    = !rise && (to_cnt == TO_LIM - 32'd1);
  // At frame start the shadow is being reloaded this edge, so compare against the new width.
  assign pulse_now = (frame_cnt == '0) ? pulse : pulse_act;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      en    <= 1'b0;
      pulse <= MINP;
    end else begin
      if (wr_ctrl)  en    <= avs_writedata[0];
      if (wr_pulse) pulse <= clamp_pulse(avs_writedata);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_cnt <= '0;
      pulse_act <= MINP;
      pwm_out   <= 1'b0;
    end else begin
      if (frame_cnt == '0) pulse_act <= pulse;
      pwm_out <= en && (frame_cnt < pulse_now);
      if (wr_ctrl && avs_writedata[1]) frame_cnt <= '0;
      else if (frame_cnt == LAST)      frame_cnt <= '0;
      else                             frame_cnt <= frame_cnt + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      resp_s1  <= 1'b0;
      resp_s2  <= 1'b0;
      resp_d   <= 1'b0;
      state    <= S_IDLE;
      meas_cnt <= '0;
      meas     <= '0;
    end else begin
      resp_s1 <= pwm_response;
      resp_s2 <= resp_s1;
      resp_d  <= resp_s2;
      case (state)
        S_IDLE: if (rise) begin
          state    <= S_HIGH;
          meas_cnt <= '0;
        end
        S_HIGH: begin
          if (meas_cnt != MEAS_MAX) meas_cnt <= meas_cnt + 1'b1;
          if (fall) state <= S_DONE;
        end
        S_DONE: begin
          meas  <= meas_cnt;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Sticky status: a set event in the same cycle as a STATUS read survives the clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      to_cnt     <= '0;
      meas_valid <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      if (rise)                 to_cnt <= '0;
      else if (to_cnt < TO_LIM) to_cnt <= to_cnt + 32'd1;
      meas_valid <= (state == S_DONE) || (meas_valid && !rd_status);
      timeout    <= to_set || (timeout && !rd_status);
    end
  end

  always_comb begin
    rd_mux = '0;
    case (avs_address)
      2'd0: rd_mux = {31'd0, en};
      2'd1: rd_mux = pulse;
      2'd2: rd_mux = 32'(meas);
      2'd3: rd_mux = {30'd0, timeout, meas_valid};
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      avs_readdata <= '0;
    else if (avs_read) avs_readdata <= rd_mux;
  end

endmodule

// File: tb/tb_servo_pwm_avalon.sv
// Bench for servo_pwm_avalon with a shortened frame: read and pulse-width scoreboards fed by directed stimulus.
module tb_servo_pwm_avalon;
  localparam int P    = 200;
  localparam int MINP = 50;
  localparam int MAXP = 100;
  localparam int MW   = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  avs_address = '0;
  logic        avs_write = 1'b0;
  logic [31:0] avs_writedata = '0;
  logic        avs_read = 1'b0;
  logic [31:0] avs_readdata;
  logic        pwm_out;
  logic        pwm_response = 1'b0;

  servo_pwm_avalon #(.PERIOD_CYCLES(P), .MIN_PULSE(MINP), .MAX_PULSE(MAXP), .MEAS_W(MW)) dut (
    .clk(clk), .reset_n(reset_n), .avs_address(avs_address), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_read(avs_read), .avs_readdata(avs_readdata),
    .pwm_out(pwm_out), .pwm_response(pwm_response)
  );

  // clock / cycle count
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;
  logic [31:0] exp_q[$];
  int          tol_q[$];
  string       name_q[$];
  int          pwm_q[$];
  bit          mon_en = 1'b0;

  task automatic check(input string name, input longint act, input longint exp, input int tol);
    longint diff;
    diff = (act > exp) ? act - exp : exp - act;
    total++;
    if (diff > tol) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (tol %0d) at cycle %0d", name, act, exp, tol, cyc);
    end
  endtask

  // read scoreboard monitor
  initial forever begin
    @(posedge clk);
    if (avs_read) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rd_unexpected: got %0d with no expected entry", avs_readdata);
      end else begin
        check(name_q.pop_front(), avs_readdata, exp_q.pop_front(), tol_q.pop_front());
      end
    end
  end

  // pwm monitor: pulse widths against pwm_q, rise-to-rise spacing against the frame length
  logic prev_pwm = 1'b0;
  int   run = 0;
  int   last_rise = -1;
  initial forever begin
    @(negedge clk);
    if (!mon_en) begin
      run = 0;
      last_rise = -1;
    end else begin
      if (pwm_out && !prev_pwm) begin
        if (last_rise >= 0) check("pwm_period", cyc - last_rise, P, 0);
        last_rise = cyc;
      end
      if (pwm_out) run++;
      if (!pwm_out && prev_pwm) begin
        if (pwm_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL pwm_extra: pulse of %0d cycles with no expected entry", run);
        end else begin
          check("pwm_width", run, pwm_q.pop_front(), 0);
        end
        run = 0;
      end
    end
    prev_pwm = pwm_out;
  end

  // driver tasks
  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    avs_address = a; avs_writedata = d; avs_write = 1'b1;
    @(posedge clk); #1;
    avs_write = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, input logic [31:0] exp, input string name, input int tol);
    @(posedge clk); #1;
    avs_address = a; avs_read = 1'b1;
    exp_q.push_back(exp); tol_q.push_back(tol); name_q.push_back(name);
    @(posedge clk); #1;
    avs_read = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic wait_pwm_rise(input string name);
    int k;
    k = 0;
    @(negedge clk);
    while (pwm_out && k < 1000) begin @(negedge clk); k++; end
    while (!pwm_out && k < 1000) begin @(negedge clk); k++; end
    if (k >= 1000) begin
      total++;
      bad++;
      $display("FAIL %s: no pwm rise within 1000 cycles, pwm=%0b", name, pwm_out);
    end
  endtask

  task automatic drive_response(input int h);
    @(posedge clk); #1;
    pwm_response = 1'b1;
    repeat (h) @(posedge clk);
    #1 pwm_response = 1'b0;
  endtask

  task automatic count_high(input int n, output int highs);
    highs = 0;
    repeat (n) begin
      @(negedge clk);
      if (pwm_out) highs++;
    end
  endtask

  int highs;
  logic [31:0] exp_lo, exp_hi;

  initial begin
`ifdef SERVO_PWM_CLAMP_EN
    exp_lo = 32'(MINP); exp_hi = 32'(MAXP);
`else
    exp_lo = 32'd10;    exp_hi = 32'(P);
`endif
    // reset values
    repeat (3) @(negedge clk);
    check("rst_pwm", pwm_out, 0, 0);
    check("rst_readdata", avs_readdata, 0, 0);
    reset_n = 1'b1;
    bus_read(2'd0, 32'd0, "rst_ctrl", 0);
    bus_read(2'd1, 32'(MINP), "rst_pulse", 0);
    bus_read(2'd2, 32'd0, "rst_meas", 0);
    bus_read(2'd3, 32'd0, "rst_status", 0);
    count_high(250, highs);
    check("disabled_low", highs, 0, 0);

    // 75-cycle pulses, then a mid-frame change to 60
    bus_write(2'd1, 32'd75);
    bus_read(2'd1, 32'd75, "pulse_rb75", 0);
    repeat (3) pwm_q.push_back(75);
    mon_en = 1'b1;
    bus_write(2'd0, 32'd3);
    wait_pwm_rise("rise1");
    wait_pwm_rise("rise2");
    wait_pwm_rise("rise3");
    wait_cycles(29);
    bus_write(2'd1, 32'd60);
    pwm_q.push_back(60);
    pwm_q.push_back(60);
    wait_pwm_rise("rise4");
    wait_pwm_rise("rise5");
    wait_cycles(70);
    mon_en = 1'b0;
    bus_read(2'd0, 32'd1, "ctrl_en", 0);

    // timeout has fired with no response edges; read clears it
    bus_read(2'd3, 32'd2, "status_timeout", 0);
    bus_read(2'd3, 32'd0, "status_cleared", 0);

    // measurement
    drive_response(62);
    wait_cycles(10);
    bus_read(2'd2, 32'd62, "meas_62", 1);
    bus_read(2'd3, 32'd1, "status_valid", 0);
    bus_read(2'd3, 32'd0, "status_valid_clr", 0);

    // timeout then a response: both bits until read
    wait_cycles(450);
    drive_response(20);
    wait_cycles(10);
    bus_read(2'd3, 32'd3, "status_both", 0);
    bus_read(2'd2, 32'd20, "meas_20", 1);
    bus_read(2'd3, 32'd0, "status_both_clr", 0);
    wait_cycles(300);
    bus_read(2'd3, 32'd0, "to_cnt_restarted", 0);

    // saturation of the measurement counter
    drive_response(300);
    wait_cycles(10);
    bus_read(2'd2, 32'd255, "meas_sat", 0);
    bus_read(2'd3, 32'd1, "status_sat", 0);

    // clamp
    bus_write(2'd1, 32'd10);
    bus_read(2'd1, exp_lo, "clamp_lo", 0);
    bus_write(2'd1, 32'd2000);
    bus_read(2'd1, exp_hi, "clamp_hi", 0);
`ifdef SERVO_PWM_CLAMP_EN
    bus_write(2'd0, 32'd0);
    wait_cycles(2);
    pwm_q.push_back(MAXP);
    pwm_q.push_back(MAXP);
    mon_en = 1'b1;
    bus_write(2'd0, 32'd3);
    wait_pwm_rise("clamp_rise1");
    wait_pwm_rise("clamp_rise2");
    wait_cycles(110);
    mon_en = 1'b0;
    wait_pwm_rise("dis_rise");
`else
    wait_cycles(450);
    count_high(250, highs);
    check("const_high", highs, 250, 0);
    bus_write(2'd1, 32'd0);
    bus_read(2'd1, 32'd0, "pulse_zero", 0);
    wait_cycles(450);
    count_high(250, highs);
    check("const_low", highs, 0, 0);
    bus_write(2'd1, 32'(P));
    wait_cycles(450);
`endif
    bus_write(2'd0, 32'd0);
    @(posedge clk); @(negedge clk);
    check("disable_low", pwm_out, 0, 0);

    // async reset during a pulse
    bus_write(2'd1, 32'd75);
    bus_read(2'd1, 32'd75, "pre_rst_pulse", 0);
    bus_write(2'd0, 32'd3);
    wait_pwm_rise("pre_rst_rise");
    wait_cycles(10);
    #3 reset_n = 1'b0;
    #1;
    check("async_rst_pwm", pwm_out, 0, 0);
    check("async_rst_readdata", avs_readdata, 0, 0);
    wait_cycles(2);
    @(negedge clk) reset_n = 1'b1;
    bus_read(2'd0, 32'd0, "rst2_ctrl", 0);
    bus_read(2'd1, 32'(MINP), "rst2_pulse", 0);
    bus_read(2'd2, 32'd0, "rst2_meas", 0);
    bus_read(2'd3, 32'd0, "rst2_status", 0);
    count_high(450, highs);
    check("rst2_no_pulse", highs, 0, 0);

    wait_cycles(3);
    check("rd_queue_empty", exp_q.size(), 0, 0);
    check("pwm_queue_empty", pwm_q.size(), 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: run exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
